// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : iir_pkg
// Desc     : Shared FSM encoding and sizing helpers for the multi-cycle IIR core.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } iir_state_e;

  // Coefficient file holds b0..bN followed by a1..aN.
  function automatic int coef_aw(input int order);
    return $clog2(2 * order + 1);
  endfunction

  function automatic int acc_width(input int nb, input int cw, input int order);
    return nb + cw + coef_aw(order);
  endfunction

  // First address of the feedback (a) coefficient bank.
  function automatic int a_base(input int order);
    return order + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iir_mac.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac
// Desc     : Signed CW x NB multiplier feeding an add/subtract accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module iir_mac #(
  parameter int NB = 10,
  parameter int CW = 12,
  parameter int AW = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_sub,
  input  logic signed [CW-1:0] i_coef,
  input  logic signed [NB-1:0] i_data,
  output logic signed [AW-1:0] o_acc
);

  logic signed [NB+CW-1:0] w_prod;
  logic signed [AW-1:0]    w_prod_ext;
  logic signed [AW-1:0]    r_acc;

  assign w_prod     = (NB+CW)'(i_coef) * (NB+CW)'(i_data);
  assign w_prod_ext = AW'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/iir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : iir_filter_mc
// Desc     : Parametrised direct-form-I IIR filter, one shared MAC, 2N+2 cycles
//            per sample behind a ready/valid handshake.
// Options  : IIR_SAT_EN - clamp the output to NB bits instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module iir_filter_mc
  import iir_pkg::*;
#(
  parameter int NB    = 10,
  parameter int CW    = 12,
  parameter int ORDER = 8,
  parameter int FRAC  = 9
) (
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic signed [NB-1:0]      DIN,
  input  logic                      VIN,
  output logic                      RDY,
  input  logic                      COEF_WE,
  input  logic [coef_aw(ORDER)-1:0] COEF_ADDR,
  input  logic signed [CW-1:0]      COEF_DATA,
  output logic signed [NB-1:0]      DOUT,
  output logic                      VOUT
);

  localparam int c_caw   = coef_aw(ORDER);
  localparam int c_acc_w = acc_width(NB, CW, ORDER);
  localparam int c_ntaps = 2 * ORDER + 1;
  localparam int c_abase = a_base(ORDER);
  localparam logic signed [c_acc_w-1:0] c_ymax = c_acc_w'((2 ** (NB - 1)) - 1);
  localparam logic signed [c_acc_w-1:0] c_ymin = c_acc_w'(-(2 ** (NB - 1)));

  iir_state_e               r_state, w_state_nxt;
  logic [c_caw-1:0]         r_tap, w_tap_nxt;
  logic                     w_accept, w_mac_en, w_mac_sub, w_out;
  logic signed [NB-1:0]     r_x    [0:ORDER];
  logic signed [NB-1:0]     r_y    [0:ORDER-1];
  logic signed [CW-1:0]     r_coef [0:c_ntaps-1];
  logic signed [CW-1:0]     w_coef;
  logic signed [NB-1:0]     w_data;
  logic signed [c_acc_w-1:0] w_acc, w_shift;
  logic signed [NB-1:0]     w_y;
  logic signed [NB-1:0]     r_dout;
  logic                     r_vout;
  logic                     w_unused_shift;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= IDLE;
      r_tap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= w_tap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    w_accept    = 1'b0;
    w_mac_en    = 1'b0;
    w_out       = 1'b0;
    case (r_state)
      IDLE: begin
        if (VIN) begin
          w_accept    = 1'b1;
          w_tap_nxt   = '0;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (r_tap == c_caw'(c_ntaps - 1)) begin
          w_state_nxt = OUT;
        end else begin
          w_tap_nxt = r_tap + 1'b1;
        end
      end
      OUT: begin
        w_out       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign RDY       = (r_state == IDLE);
  assign w_mac_sub = (r_tap >= c_caw'(c_abase));

  // Operand select by tap compare keeps the index width independent of ORDER.
  always_comb begin
    w_coef = '0;
    w_data = '0;
    for (int k = 0; k < c_ntaps; k++) begin
      if (r_tap == c_caw'(k)) w_coef = r_coef[k];
    end
    for (int k = 0; k <= ORDER; k++) begin
      if (r_tap == c_caw'(k)) w_data = r_x[k];
    end
    for (int k = 0; k < ORDER; k++) begin
      if (r_tap == c_caw'(k + c_abase)) w_data = r_y[k];
    end
  end

  // x[n] lands in slot 0 at acceptance; history shifts only when the output is produced.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k <= ORDER; k++) r_x[k] <= '0;
      for (int k = 0; k < ORDER; k++) r_y[k] <= '0;
      for (int k = 0; k < c_ntaps; k++) r_coef[k] <= '0;
    end else begin
      if (w_accept) r_x[0] <= DIN;
      if (COEF_WE && (r_state == IDLE)) begin
        for (int k = 0; k < c_ntaps; k++) begin
          if (COEF_ADDR == c_caw'(k)) r_coef[k] <= COEF_DATA;
        end
      end
      if (w_out) begin
        for (int k = 1; k <= ORDER; k++) r_x[k] <= r_x[k-1];
        for (int k = 1; k < ORDER; k++) r_y[k] <= r_y[k-1];
        r_y[0] <= w_y;
      end
    end
  end

  iir_mac #(
    .NB (NB),
    .CW (CW),
    .AW (c_acc_w)
  ) u_mac (
    .clk    (CLK),
    .rst_n  (RST_n),
    .i_clr  (w_accept),
    .i_en   (w_mac_en),
    .i_sub  (w_mac_sub),
    .i_coef (w_coef),
    .i_data (w_data),
    .o_acc  (w_acc)
  );

  always_comb begin
    w_shift = w_acc >>> FRAC;
`ifdef IIR_SAT_EN
    if (w_shift > c_ymax) begin
      w_y = NB'(c_ymax);
    end else if (w_shift < c_ymin) begin
      w_y = NB'(c_ymin);
    end else begin
      w_y = NB'(w_shift);
    end
`else
    w_y = NB'(w_shift);
`endif
  end

  assign w_unused_shift = ^w_shift;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_dout <= '0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= w_out;
      if (w_out) r_dout <= w_y;
    end
  end

  assign DOUT = r_dout;
  assign VOUT = r_vout;

endmodule
`default_nettype wire

// File: tb/tb_iir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_filter_mc
// Desc     : Self-checking bench for iir_filter_mc (default 8th order, 10-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_filter_mc;

  localparam int c_lat = 18;

  logic                clk;
  logic                r_rst_n;
  logic signed [9:0]   r_din;
  logic                r_vin;
  logic                w_rdy;
  logic                r_coef_we;
  logic [4:0]          r_coef_addr;
  logic signed [11:0]  r_coef_data;
  logic signed [9:0]   w_dout;
  logic                w_vout;

  iir_filter_mc dut (
    .CLK       (clk),
    .RST_n     (r_rst_n),
    .DIN       (r_din),
    .VIN       (r_vin),
    .RDY       (w_rdy),
    .COEF_WE   (r_coef_we),
    .COEF_ADDR (r_coef_addr),
    .COEF_DATA (r_coef_data),
    .DOUT      (w_dout),
    .VOUT      (w_vout)
  );

  typedef struct { int exp_y; int t; } exp_t;
  typedef struct { int cfg; int din; int exp_y; } vec_t;

  exp_t  sb[$];
  vec_t  tbl[13];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    r_cyc    = 0;
  string phase    = "init";
  int    mcoef[17];
  int    mx[9];
  int    my[8];
  bit    pw_en    = 1'b0;
  int    pw_addr  = 0;
  int    pw_data  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) r_cyc <= r_cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s/%s: got %0d, required %0d", phase, name, act, req);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s/%s: bound expired waiting for DUT", phase, name);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 17; k++) mcoef[k] = 0;
    for (int k = 0; k < 9; k++) mx[k] = 0;
    for (int k = 0; k < 8; k++) my[k] = 0;
  endfunction

  // Reference: y = (sum b*x - sum a*y) >>> 9, then clamp or wrap to 10 bits.
  function automatic int model_step(input int d);
    longint acc;
    longint s;
    int     y;
    for (int k = 8; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
    acc = 0;
    for (int k = 0; k <= 8; k++) acc += longint'(mcoef[k]) * longint'(mx[k]);
    for (int k = 0; k < 8; k++) acc -= longint'(mcoef[9+k]) * longint'(my[k]);
    s = acc >>> 9;
`ifdef IIR_SAT_EN
    if (s > 511) y = 511;
    else if (s < -512) y = -512;
    else y = int'(s);
`else
    y = int'(s & 64'd1023);
    if (y >= 512) y -= 1024;
`endif
    for (int k = 7; k > 0; k--) my[k] = my[k-1];
    my[0] = y;
    return y;
  endfunction

  always @(negedge clk) begin
    if (r_rst_n && w_vout) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL %s/vout_unexpected: got VOUT=1, required no output", phase);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", longint'(w_dout), longint'(e.exp_y));
        check("latency", longint'(r_cyc - e.t), longint'(c_lat));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    r_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    r_rst_n = 1'b1;
    model_clear();
    sb.delete();
  endtask

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    r_coef_we   = 1'b1;
    r_coef_addr = 5'(a);
    r_coef_data = 12'(v);
    if (w_rdy && a <= 16) mcoef[a] = v;
    @(negedge clk);
    r_coef_we = 1'b0;
  endtask

  // Returns on the negedge after the acceptance edge.
  task automatic send(input int d, input bit use_tbl, input int texp);
    int n;
    int y;
    n = 0;
    @(negedge clk);
    while (!w_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!w_rdy) begin
      fail_bound("rdy_wait");
      return;
    end
    r_din = 10'(d);
    r_vin = 1'b1;
    if (pw_en) begin
      r_coef_we   = 1'b1;
      r_coef_addr = 5'(pw_addr);
      r_coef_data = 12'(pw_data);
      if (pw_addr <= 16) mcoef[pw_addr] = pw_data;
    end
    y = model_step(d);
    sb.push_back('{exp_y: (use_tbl ? texp : y), t: r_cyc + 1});
    @(negedge clk);
    r_vin     = 1'b0;
    r_coef_we = 1'b0;
    pw_en     = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_bound("drain");
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load_cfg(input int cfg);
    case (cfg)
      0: write_coef(0, 512);
      1: begin write_coef(0, 512); write_coef(9, -256); end
      default: write_coef(0, 2047);
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cur_cfg;
    int lows;
    int n;
    int d;
    int y;
    int sat_exp;
    int b_full[9];
    int a_full[8];

`ifdef IIR_SAT_EN
    sat_exp = 511;
`else
    sat_exp = -5;
`endif
    tbl[0]  = '{0, 100, 100};
    tbl[1]  = '{0, -37, -37};
    tbl[2]  = '{1, 256, 256};
    tbl[3]  = '{1, 0, 128};
    tbl[4]  = '{1, 0, 64};
    tbl[5]  = '{1, 0, 32};
    tbl[6]  = '{1, 0, 16};
    tbl[7]  = '{1, 0, 8};
    tbl[8]  = '{1, 0, 4};
    tbl[9]  = '{1, 0, 2};
    tbl[10] = '{1, 0, 1};
    tbl[11] = '{1, 0, 0};
    tbl[12] = '{2, 511, sat_exp};
    b_full = '{1, 9, 32, 65, 81, 65, 32, 9, 1};
    a_full = '{-815, 1066, -785, 445, -164, 42, -7, 0};

    r_rst_n = 1'b0; r_din = '0; r_vin = 1'b0;
    r_coef_we = 1'b0; r_coef_addr = '0; r_coef_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    r_rst_n = 1'b1;
    @(negedge clk);
    phase = "reset";
    check("dout", longint'(w_dout), 0);
    check("vout", longint'(w_vout), 0);
    check("rdy", longint'(w_rdy), 1);

    phase = "table";
    cur_cfg = -1;
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].cfg != cur_cfg) begin
        wait_drain();
        do_reset();
        load_cfg(tbl[i].cfg);
        cur_cfg = tbl[i].cfg;
      end
      send(tbl[i].din, 1'b1, tbl[i].exp_y);
    end
    wait_drain();

    phase = "rdy_low";
    do_reset();
    load_cfg(0);
    send(77, 1'b0, 0);
    lows = 0;
    while (!w_rdy && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    check("rdy_low_cycles", longint'(lows), longint'(c_lat));
    wait_drain();

    // Coefficient write on the acceptance edge applies to that sample.
    phase = "we_with_vin";
    do_reset();
    write_coef(0, 512);
    pw_en = 1'b1; pw_addr = 9; pw_data = -256;
    send(256, 1'b0, 0);
    send(0, 1'b0, 0);
    wait_drain();

    phase = "we_in_mac";
    send(50, 1'b0, 0);
    write_coef(0, 1024);
    write_coef(9, 300);
    wait_drain();
    write_coef(20, 777);
    send(60, 1'b0, 0);
    send(-40, 1'b0, 0);
    wait_drain();

    phase = "reset_mid_mac";
    n = 0;
    @(negedge clk);
    while (!w_rdy && n < 100) begin @(negedge clk); n++; end
    r_din = 10'sd200;
    r_vin = 1'b1;
    @(negedge clk);
    r_vin = 1'b0;
    repeat (5) @(negedge clk);
    r_rst_n = 1'b0;
    #1;
    check("dout", longint'(w_dout), 0);
    check("vout", longint'(w_vout), 0);
    check("rdy", longint'(w_rdy), 1);
    @(negedge clk);
    @(negedge clk);
    r_rst_n = 1'b1;
    model_clear();
    load_cfg(1);
    send(256, 1'b1, 256);
    send(0, 1'b1, 128);
    wait_drain();

    phase = "vin_held";
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r_vin = 1'b1;
      d = int'($urandom_range(0, 200)) - 100;
      r_din = 10'(d);
      if (w_rdy) begin
        y = model_step(d);
        sb.push_back('{exp_y: y, t: r_cyc + 1});
      end
    end
    @(negedge clk);
    r_vin = 1'b0;
    wait_drain();

    phase = "full_order";
    do_reset();
    for (int k = 0; k < 9; k++) write_coef(k, b_full[k]);
    for (int k = 0; k < 8; k++) write_coef(9 + k, a_full[k]);
    for (int i = 0; i < 30; i++) begin
      d = (i < 10) ? 300 : (int'($urandom_range(0, 1000)) - 500);
      send(d, 1'b0, 0);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
